ac_unit: RTL and testbench
==========================

Name: ac_unit

Overview:
- Accumulator stage directly downstream of the basic-computer ALU.
- Accepts one accumulator-class command per handshake and drives the ALU operand and op lines.
- Captures the ALU result, E_out and flags into the architectural AC, E and flag registers.
- Produces the skip decision for the register-reference skip instructions, consumed by the PC-increment logic in the control sequencer.

Parameters:
- W, 16, datapath width of AC, DR and the ALU.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd  in  4  command code (see Behaviour)
- dr_in  in  W  DR operand, sampled with the command
- alu_op  out  3  ALU op select
- alu_ac  out  W  ALU AC operand (always the AC register)
- alu_dr  out  W  ALU DR operand
- alu_e_in  out  1  ALU E input (always the E register)
- alu_out  in  W  ALU result
- alu_e_out  in  1  ALU E output
- alu_co, alu_ovf, alu_z, alu_n  in  1 each  ALU flags
- ac  out  W  AC register
- e  out  1  E flip-flop
- flags  out  4  {CO, OVF, Z, N} flag register
- done  out  1  one-cycle pulse: command retired
- skip  out  1  valid only with done: skip next instruction
- illegal  out  1  valid only with done: reserved command retired

Behaviour:
- Reset:
  - The following are cleared asynchronously: ac=0, e=0, flags=0, done=0, skip=0, illegal=0, state=IDLE, latched cmd/dr=0.
  - Reset mid-EXEC discards the command with no writeback and no done.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge, latch cmd and dr_in and go to EXEC.
  - cmd/dr_in are ignored when cmd_valid=0.
- EXEC:
  - cmd_ready=0.
  - ALU drive is combinational from the latched command.
  - Next edge: writeback, done/skip/illegal registered high for exactly one cycle, return to IDLE.
- Latency and throughput:
  - Accept at edge k; new ac/e/flags and done visible after edge k+1.
  - cmd_ready is high again in that same cycle.
  - Maximum throughput is 1 command per 2 cycles.
  - A command offered while done is high is legal.
- ALU drive in IDLE: alu_op=110 (transfer AC), alu_dr=latched dr.
- Commands. Each entry gives ALU op / alu_dr / AC / E:
  - 0 ADD: op 000 / dr / AC<=alu_out / E<=alu_e_out
  - 1 AND: op 001 / dr / AC<=alu_out / E unchanged
  - 2 LDA: op 010 / dr / AC<=alu_out / E unchanged
  - 3 CMA: op 011 / – / AC<=alu_out / E unchanged
  - 4 CIR: op 100 / – / AC<=alu_out / E<=alu_e_out
  - 5 CIL: op 101 / – / AC<=alu_out / E<=alu_e_out
  - 6 CLA: op 001 / 0 / AC<=alu_out (=0) / E unchanged
  - 7 CLE: no AC write / E<=0
  - 8 CME: no AC write / E<=~E
  - 9 INC: op 000 / 1 / AC<=alu_out / E unchanged (carry not written to E)
  - 10 SPA: skip=~ac[W-1]
  - 11 SNA: skip=ac[W-1]
  - 12 SZA: skip=(ac==0)
  - 13 SZE: skip=~e
  - 14 NOP: nothing
  - 15 reserved: no state change, illegal=1
- Flags:
  - Commands 0–6 and 9 load flags<={alu_co, alu_ovf, alu_z, alu_n}.
  - All other commands leave flags unchanged.
- Skip:
  - Evaluated from the registered ac/e during EXEC, pre-writeback.
  - Commands 10–13 never modify ac, e or flags.
  - skip=0 for all non-skip commands.
- Arithmetic wraps modulo 2^W; overflow is reported only through flags.

Decomposition:
- Shared package ac_pkg holds:
  - the 4-bit command encodings (CMD_ADD … CMD_RSVD);
  - the ALU op constants (ALU_ADD=000, ALU_AND=001, ALU_LDDR=010, ALU_CMA=011, ALU_SHR=100, ALU_SHL=101, ALU_PASS=110);
  - the state enum {IDLE, EXEC}.
- One natural sub-module is ac_skip_eval: combinational skip decode from cmd, ac, e.
- Everything else stays in ac_unit.
- The ALU stays external, connected at top level.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC of an LDA 0x1234 -> ac=0, e=0, flags=0, no done; after release, cmd_ready=1.
- ADD: LDA 0xFFFF, then ADD dr=0x0001 -> ac=0x0000, e=1, flags CO=1, OVF=0, Z=1, N=0; done one cycle after accept edge.
- Overflow: LDA 0x7FFF, then INC -> ac=0x8000, OVF=1, N=1, e unchanged (0).
- Rotate: LDA 0x8001, CLE, then CIL -> ac=0x0002, e=1; then CIR -> ac=0x8001, e=0.
- Skips:
  - ac=0x0000: SZA -> skip=1; SNA -> skip=0; SPA -> skip=1.
  - e=1: SZE -> skip=0.
  - ac, e, flags unchanged throughout.
- Handshake/illegal: hold cmd_valid=1 with back-to-back CME, CME, cmd 15 -> accepts every 2 cycles, e toggles twice back to its original value, third done has illegal=1 with no state change.

Source files
------------

// File: rtl/ac_pkg.sv
// ac_pkg: command codes, ALU op selects and FSM state type shared by the accumulator stage
package ac_pkg;
  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_AND  = 4'd1;
  localparam logic [3:0] CMD_LDA  = 4'd2;
  localparam logic [3:0] CMD_CMA  = 4'd3;
  localparam logic [3:0] CMD_CIR  = 4'd4;
  localparam logic [3:0] CMD_CIL  = 4'd5;
  localparam logic [3:0] CMD_CLA  = 4'd6;
  localparam logic [3:0] CMD_CLE  = 4'd7;
  localparam logic [3:0] CMD_CME  = 4'd8;
  localparam logic [3:0] CMD_INC  = 4'd9;
  localparam logic [3:0] CMD_SPA  = 4'd10;
  localparam logic [3:0] CMD_SNA  = 4'd11;
  localparam logic [3:0] CMD_SZA  = 4'd12;
  localparam logic [3:0] CMD_SZE  = 4'd13;
  localparam logic [3:0] CMD_NOP  = 4'd14;
  localparam logic [3:0] CMD_RSVD = 4'd15;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_LDDR = 3'b010;
  localparam logic [2:0] ALU_CMA  = 3'b011;
  localparam logic [2:0] ALU_SHR  = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;
  typedef enum logic {IDLE, EXEC} state_t;
endpackage

// File: rtl/ac_unit_skip_eval.sv
// ac_skip_eval: skip decision for the register-reference skip commands, from pre-writeback AC/E
module ac_skip_eval
  import ac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0]   cmd,
  input  logic [W-1:0] ac,
  input  logic         e,
  output logic         skip
);
  // non-skip commands never skip
  always_comb
    skip = cmd == CMD_SPA ? ~ac[W-1] :
           cmd == CMD_SNA ? ac[W-1] :
           cmd == CMD_SZA ? (ac == '0) :
           cmd == CMD_SZE ? ~e : 1'b0;
endmodule

// File: rtl/ac_unit.sv
// ac_unit: accumulator stage driving the external ALU and holding AC, E and flags
module ac_unit
  import ac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd,
  input  logic [W-1:0] dr_in,
  output logic [2:0]   alu_op,
  output logic [W-1:0] alu_ac,
  output logic [W-1:0] alu_dr,
  output logic         alu_e_in,
  input  logic [W-1:0] alu_out,
  input  logic         alu_e_out,
  input  logic         alu_co,
  input  logic         alu_ovf,
  input  logic         alu_z,
  input  logic         alu_n,
  output logic [W-1:0] ac,
  output logic         e,
  output logic [3:0]   flags,
  output logic         done,
  output logic         skip,
  output logic         illegal
);
  state_t state;
  logic [3:0] cmd_q;
  logic [W-1:0] dr_q;
  logic skip_c;
  logic wr_ac;
  assign cmd_ready = state == IDLE;
  assign alu_ac = ac;
  assign alu_e_in = e;
  assign wr_ac = cmd_q <= CMD_CLA || cmd_q == CMD_INC;
  ac_skip_eval #(.W(W)) u_skip (.cmd(cmd_q), .ac(ac), .e(e), .skip(skip_c));
  // ALU drive decoded from the latched command; IDLE and non-ALU commands pass AC through
  always_comb begin
    alu_op = ALU_PASS;
    alu_dr = dr_q;
    if (state == EXEC) begin
      case (cmd_q)
        CMD_ADD: alu_op = ALU_ADD;
        CMD_AND: alu_op = ALU_AND;
        CMD_LDA: alu_op = ALU_LDDR;
        CMD_CMA: alu_op = ALU_CMA;
        CMD_CIR: alu_op = ALU_SHR;
        CMD_CIL: alu_op = ALU_SHL;
        CMD_CLA: begin alu_op = ALU_AND; alu_dr = '0; end
        CMD_INC: begin alu_op = ALU_ADD; alu_dr = W'(1); end
        default: alu_op = ALU_PASS;
      endcase
    end
  end
  // two-state handshake FSM: latch in IDLE, write back and pulse done from EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_q   <= '0;
      dr_q    <= '0;
      ac      <= '0;
      e       <= 1'b0;
      flags   <= '0;
      done    <= 1'b0;
      skip    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done    <= 1'b0;
      skip    <= 1'b0;
      illegal <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          cmd_q <= cmd;
          dr_q  <= dr_in;
          state <= EXEC;
        end
      end else begin
        if (wr_ac) begin
          ac    <= alu_out;
          flags <= {alu_co, alu_ovf, alu_z, alu_n};
        end
        if (cmd_q == CMD_ADD || cmd_q == CMD_CIR || cmd_q == CMD_CIL) e <= alu_e_out;
        else if (cmd_q == CMD_CLE) e <= 1'b0;
        else if (cmd_q == CMD_CME) e <= ~e;
        done    <= 1'b1;
        skip    <= skip_c;
        illegal <= cmd_q == CMD_RSVD;
        state   <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ac_unit.sv
// tb_ac_unit: directed vectors against ac_unit with a behavioural basic-computer ALU attached
module tb_ac_unit;
  localparam int W = 16;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic [3:0] cmd = '0;
  logic [W-1:0] dr_in = '0;
  logic cmd_ready, alu_e_in, alu_e_out, alu_co, alu_ovf, alu_z, alu_n, e, done, skip, illegal;
  logic [2:0] alu_op;
  logic [W-1:0] alu_ac, alu_dr, alu_out, ac;
  logic [3:0] flags;
  logic [W:0] sum;
  int vectors = 0, miscompares = 0;

  ac_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .dr_in(dr_in), .alu_op(alu_op), .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e_in(alu_e_in),
    .alu_out(alu_out), .alu_e_out(alu_e_out), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .alu_z(alu_z), .alu_n(alu_n), .ac(ac), .e(e), .flags(flags), .done(done),
    .skip(skip), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always_comb begin
    sum = {1'b0, alu_ac} + {1'b0, alu_dr};
    alu_out = alu_ac;
    alu_e_out = alu_e_in;
    alu_co = 1'b0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_out = sum[W-1:0];
        alu_co = sum[W];
        alu_e_out = sum[W];
        alu_ovf = (alu_ac[W-1] == alu_dr[W-1]) && (sum[W-1] != alu_ac[W-1]);
      end
      3'b001: alu_out = alu_ac & alu_dr;
      3'b010: alu_out = alu_dr;
      3'b011: alu_out = ~alu_ac;
      3'b100: begin alu_out = {alu_e_in, alu_ac[W-1:1]}; alu_e_out = alu_ac[0]; end
      3'b101: begin alu_out = {alu_ac[W-2:0], alu_e_in}; alu_e_out = alu_ac[W-1]; end
      default: alu_out = alu_ac;
    endcase
    alu_z = alu_out == '0;
    alu_n = alu_out[W-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [W-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = c;
    dr_in = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    #1;
    check("rst_ac", ac, 0);
    check("rst_e", e, 0);
    check("rst_flags", flags, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_ready, 1);
    check("idle_op", alu_op, 3'b110);
    issue(4'd2, 16'h8000);
    check("lda_ac", ac, 16'h8000);
    check("lda_flags", flags, 4'b0001);
    check("lda_done", done, 1);
    issue(4'd8, 16'h0000);
    check("cme_e", e, 1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 4'd2;
    dr_in = 16'h1234;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("mid_exec_ready", cmd_ready, 0);
    rst_n = 1'b0;
    #2;
    check("mrst_ac", ac, 0);
    check("mrst_e", e, 0);
    check("mrst_flags", flags, 0);
    check("mrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_nodone", done, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_ac2", ac, 0);
    issue(4'd2, 16'hFFFF);
    check("lda_ffff", ac, 16'hFFFF);
    issue(4'd0, 16'h0001);
    check("add_done", done, 1);
    check("add_ready", cmd_ready, 1);
    check("add_ac", ac, 16'h0000);
    check("add_e", e, 1);
    check("add_flags", flags, 4'b1010);
    check("add_skip", skip, 0);
    issue(4'd7, 16'h0000);
    check("cle_e", e, 0);
    check("cle_flags", flags, 4'b1010);
    issue(4'd2, 16'h7FFF);
    issue(4'd9, 16'h0000);
    check("inc_ac", ac, 16'h8000);
    check("inc_flags", flags, 4'b0101);
    check("inc_e", e, 0);
    issue(4'd2, 16'h8001);
    issue(4'd7, 16'h0000);
    issue(4'd5, 16'h0000);
    check("cil_ac", ac, 16'h0002);
    check("cil_e", e, 1);
    check("cil_flags", flags, 4'b0000);
    issue(4'd4, 16'h0000);
    check("cir_ac", ac, 16'h8001);
    check("cir_e", e, 0);
    check("cir_flags", flags, 4'b0001);
    issue(4'd6, 16'hFFFF);
    check("cla_ac", ac, 16'h0000);
    check("cla_flags", flags, 4'b0010);
    issue(4'd8, 16'h0000);
    check("cme_e1", e, 1);
    issue(4'd12, 16'h0000);
    check("sza_skip", skip, 1);
    issue(4'd11, 16'h0000);
    check("sna_skip", skip, 0);
    issue(4'd10, 16'h0000);
    check("spa_skip", skip, 1);
    issue(4'd13, 16'h0000);
    check("sze_skip", skip, 0);
    check("sze_done", done, 1);
    check("skip_ac", ac, 16'h0000);
    check("skip_e", e, 1);
    check("skip_flags", flags, 4'b0010);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd = 4'd8;
    @(posedge clk);
    #1;
    check("hs_a_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("hs_d1", done, 1);
    check("hs_d1_ready", cmd_ready, 1);
    check("hs_e1", e, 0);
    @(posedge clk);
    #1;
    check("hs_b_ready", cmd_ready, 0);
    check("hs_b_done", done, 0);
    @(posedge clk);
    #1;
    check("hs_d2", done, 1);
    check("hs_e2", e, 1);
    cmd = 4'd15;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("hs_c_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    check("hs_d3", done, 1);
    check("rsvd_illegal", illegal, 1);
    check("rsvd_skip", skip, 0);
    check("rsvd_e", e, 1);
    check("rsvd_ac", ac, 16'h0000);
    check("rsvd_flags", flags, 4'b0010);
    @(posedge clk);
    #1;
    check("pulse_done", done, 0);
    check("pulse_illegal", illegal, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
